// File: rtl/mux_pkg.sv
// Shared definitions for the arb_mux_n channel multiplexer: channel index type,
// no-grant sentinel and index helpers.
package mux_pkg;

   localparam int unsigned CH_DEFAULT   = 4;
   localparam int unsigned SELW_DEFAULT = $clog2(CH_DEFAULT);

   typedef logic [SELW_DEFAULT-1:0] ch_idx_t;

   // Index reported on the grant bus when grant_valid is low; never used to load data.
   localparam int unsigned NO_GRANT = 0;

   function automatic logic idx_ok(input int unsigned idx, input int unsigned ch);
      return idx < ch;
   endfunction

   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned ch);
      return (idx + 1 >= ch) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// Round-robin picker: first set request scanning ptr, ptr+1, ... modulo CH.
module rr_pick
   import mux_pkg::*;
#(
   parameter int unsigned CH   = 4,
   parameter int unsigned SELW = $clog2(CH)
) (
   input  logic [CH-1:0]   req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] grant,
   output logic            grant_valid
);

   always_comb begin
      int unsigned idx;
      idx         = 0;
      grant       = SELW'(NO_GRANT);
      grant_valid = 1'b0;
      for (int unsigned k = 0; k < CH; k++) begin
         idx = (32'(ptr) + k) % CH;
         if (!grant_valid && req[SELW'(idx)]) begin
            grant       = SELW'(idx);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux_n.sv
// Registered CH-channel valid/ready mux with fixed-select or round-robin grant.
// Define ARB_MUX_SKID_EN to add a one-entry skid register behind the output.
module arb_mux_n
   import mux_pkg::*;
#(
   parameter  int unsigned N    = 32,
   parameter  int unsigned CH   = 4,
   localparam int unsigned SELW = $clog2(CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 mode_rr,
   input  logic [SELW-1:0]      sel,
   input  logic [CH-1:0]        in_valid,
   input  logic [CH-1:0][N-1:0] in_data,
   output logic [CH-1:0]        in_ready,
   output logic                 out_valid,
   output logic [N-1:0]         out_data,
   output logic [SELW-1:0]      out_ch,
   input  logic                 out_ready
);

   localparam int unsigned CHP = 1 << SELW;

   logic [SELW-1:0] ptr, ptr_nxt, rr_idx, grant_idx;
   logic            rr_valid, grant_valid, load_ok, accept;
   logic [CHP-1:0]  valid_pad, ready_pad;

   rr_pick #(.CH(CH), .SELW(SELW)) u_rr_pick (
      .req         (in_valid),
      .ptr         (ptr),
      .grant       (rr_idx),
      .grant_valid (rr_valid)
   );

   // Padding to a power of two makes out-of-range sel read a zero request.
   assign valid_pad = CHP'(in_valid);

   always_comb begin
      grant_idx   = SELW'(NO_GRANT);
      grant_valid = 1'b0;
      if (mode_rr) begin
         grant_idx   = rr_idx;
         grant_valid = rr_valid;
      end else if (idx_ok(32'(sel), CH) && valid_pad[sel]) begin
         grant_idx   = sel;
         grant_valid = 1'b1;
      end
   end

   assign accept    = rst_n & ~flush & load_ok & grant_valid;
   assign ready_pad = accept ? (CHP'(1) << grant_idx) : '0;
   assign in_ready  = CH'(ready_pad);
   assign ptr_nxt   = SELW'(next_idx(32'(grant_idx), CH));

`ifdef ARB_MUX_SKID_EN
   logic            skid_valid;
   logic [N-1:0]    skid_data;
   logic [SELW-1:0] skid_ch;

   // Skid decouples in_ready from out_ready: accept whenever the skid is empty.
   assign load_ok = ~skid_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_ch    <= '0;
         ptr        <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (accept) ptr <= ptr_nxt;
         if (out_valid && out_ready) begin
            if (skid_valid) begin
               out_data   <= skid_data;
               out_ch     <= skid_ch;
               skid_valid <= 1'b0;
            end else if (accept) begin
               out_data <= in_data[grant_idx];
               out_ch   <= grant_idx;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            if (out_valid) begin
               skid_valid <= 1'b1;
               skid_data  <= in_data[grant_idx];
               skid_ch    <= grant_idx;
            end else begin
               out_valid <= 1'b1;
               out_data  <= in_data[grant_idx];
               out_ch    <= grant_idx;
            end
         end
      end
   end
`else
   assign load_ok = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data[grant_idx];
         out_ch    <= grant_idx;
         ptr       <= ptr_nxt;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule
